// File: rtl/interboard_tx_scheduler.sv
// interboard_tx_scheduler
//   Shares the single interboard transmit path between several message
//   sources. Requests are arbitrated round-robin into a small FIFO and the
//   FIFO head is sequenced into the interboard block, paced by inter_ready.
//
//   Optional feature macro: INTERBOARD_TX_RETRY_EN
//     When defined, a launch that is not acknowledged (inter_ready never
//     falls) within TIMEOUT_CYC cycles is relaunched up to 3 times. After
//     that the head is dropped and tx_err pulses.
//
// Ports
//   clk, rst                       clock, async active-low reset
//   req_valid/msg_type/number      per-requester level request + payload
//   req_grant                      one-hot accept pulse (pushed into FIFO)
//   inter_ready                    link idle / transfer complete
//   transmit, ctrl_en              one-cycle launch pulse
//   ctrl_msg_type, ctrl_number     FIFO head, stable until popped
//   busy                           FSM active or FIFO non-empty
//   fifo_count                     FIFO occupancy
//   tx_err                         message dropped after retries
module interboard_tx_scheduler #(
  parameter int NUM_REQ     = 3,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [3*NUM_REQ-1:0]          req_msg_type,
  input  logic [5*NUM_REQ-1:0]          req_number,
  output logic [NUM_REQ-1:0]            req_grant,
  input  logic                          inter_ready,
  output logic                          transmit,
  output logic                          ctrl_en,
  output logic [2:0]                    ctrl_msg_type,
  output logic [4:0]                    ctrl_number,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          tx_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef struct packed {
    logic [2:0] msg_type;
    logic [4:0] number;
  } msg_t;

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE, GAP} state_t;

  state_t         state_q, state_d;
  msg_t           mem_q [FIFO_DEPTH];
  logic [AW-1:0]  wr_q, rd_q;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]  rr_q, rr_d;

  logic           gnt_found, push, pop, head_vld, launch;
  logic [PW-1:0]  gnt_idx;
  msg_t           gnt_msg, head;
  logic           relaunch, give_up;

  // ---------------- round-robin arbiter ----------------
  always_comb begin
    int j;
    j         = 0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    gnt_msg   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(rr_q) + k) % NUM_REQ;
      if (!gnt_found && req_valid[j]) begin
        gnt_found = 1'b1;
        gnt_idx   = PW'(j);
        gnt_msg   = '{msg_type: req_msg_type[3*j +: 3], number: req_number[5*j +: 5]};
      end
    end
  end

  // Grant stays quiet while reset is held so req_grant reads 0 in reset.
  assign push = rst && gnt_found && (cnt_q != CW'(FIFO_DEPTH));
  assign rr_d = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + PW'(1);

  always_comb begin
    req_grant = '0;
    if (push) req_grant[gnt_idx] = 1'b1;
  end

  // ---------------- FIFO ----------------
  assign head_vld = (cnt_q != '0);
  assign head     = mem_q[rd_q];

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      rr_q  <= '0;
    end else begin
      if (push) begin
        wr_q <= wr_q + AW'(1);
        rr_q <= rr_d;
      end
      if (pop) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_d;
    end
  end

  // Payload storage needs no reset: outputs are masked while empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= gnt_msg;
  end

  // ---------------- optional relaunch timer ----------------
`ifdef INTERBOARD_TX_RETRY_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic [1:0]    rty_q, rty_d;
  logic          expired;

  assign expired  = (state_q == WAIT_BUSY) && inter_ready && (tmo_q == TW'(TIMEOUT_CYC));
  assign relaunch = expired && (rty_q != 2'd3);
  assign give_up  = expired && (rty_q == 2'd3);

  // Every head enters WAIT_BUSY from IDLE, so clearing outside WAIT_BUSY
  // restarts both counters per head; relaunches stay in WAIT_BUSY.
  always_comb begin
    tmo_d = tmo_q + TW'(1);
    rty_d = rty_q;
    if (state_q != WAIT_BUSY) begin
      tmo_d = '0;
      rty_d = '0;
    end else if (expired) begin
      tmo_d = '0;
      rty_d = rty_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_q <= '0;
      rty_q <= '0;
    end else begin
      tmo_q <= tmo_d;
      rty_q <= rty_d;
    end
  end
`else
  assign relaunch = 1'b0;
  assign give_up  = 1'b0;
`endif

  assign pop    = ((state_q == WAIT_DONE) && inter_ready) || give_up;
  assign launch = ((state_q == IDLE) && head_vld && inter_ready) || relaunch;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (head_vld && inter_ready) state_d = WAIT_BUSY;
      WAIT_BUSY: if (!inter_ready) state_d = WAIT_DONE;
                 else if (give_up) state_d = GAP;
      WAIT_DONE: if (inter_ready) state_d = GAP;
      GAP:       state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    transmit      = launch;
    ctrl_en       = launch;
    tx_err        = give_up;
    busy          = (state_q != IDLE) || head_vld;
    fifo_count    = cnt_q;
    ctrl_msg_type = head_vld ? head.msg_type : 3'd0;
    ctrl_number   = head_vld ? head.number   : 5'd0;
  end

endmodule

// File: tb/tb_interboard_tx_scheduler.sv
// Directed bench for interboard_tx_scheduler (NUM_REQ=3, FIFO_DEPTH=4,
// TIMEOUT_CYC=8). Inputs change 1ns after the rising edge, outputs are
// checked 1ns later.
module tb_interboard_tx_scheduler;
  localparam int NR = 3;
  localparam int FD = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [NR-1:0]   req_valid = '0;
  logic [3*NR-1:0] req_msg_type = '0;
  logic [5*NR-1:0] req_number = '0;
  logic [NR-1:0]   req_grant;
  logic            inter_ready = 1'b0;
  logic            transmit, ctrl_en, busy, tx_err;
  logic [2:0]      ctrl_msg_type;
  logic [4:0]      ctrl_number;
  logic [$clog2(FD):0] fifo_count;

  int tests = 0;
  int fails = 0;

  interboard_tx_scheduler #(.NUM_REQ(NR), .FIFO_DEPTH(FD), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_msg_type(req_msg_type),
    .req_number(req_number), .req_grant(req_grant), .inter_ready(inter_ready),
    .transmit(transmit), .ctrl_en(ctrl_en), .ctrl_msg_type(ctrl_msg_type),
    .ctrl_number(ctrl_number), .busy(busy), .fifo_count(fifo_count), .tx_err(tx_err)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; req_valid = '0; inter_ready = 1'b0;
    cyc(); cyc();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; inter_ready = 1'b0; req_valid = 3'b111;
    req_msg_type = {3'd3, 3'd2, 3'd1}; req_number = {5'd3, 5'd2, 5'd1};
    cyc(); cyc();
    tests++; if ({req_grant, transmit, ctrl_en, ctrl_msg_type, ctrl_number, busy, tx_err} !== '0) begin
      fails++; $display("FAIL reset_outputs: got %0h want 0", {req_grant, transmit, ctrl_en, ctrl_msg_type, ctrl_number, busy, tx_err}); end
    tests++; if (fifo_count !== 0) begin fails++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    rst = 1'b1; #1;
    tests++; if (req_grant !== 3'b001) begin fails++; $display("FAIL reset_g0: got %b want 001", req_grant); end
    cyc();
    tests++; if (req_grant !== 3'b010) begin fails++; $display("FAIL reset_g1: got %b want 010", req_grant); end
    cyc();
    tests++; if (req_grant !== 3'b100) begin fails++; $display("FAIL reset_g2: got %b want 100", req_grant); end
    cyc(); req_valid = '0; #1;
    tests++; if (fifo_count !== 3 || req_grant !== 0 || transmit !== 0) begin
      fails++; $display("FAIL reset_fill: count %0d grant %b tx %b want 3/000/0", fifo_count, req_grant, transmit); end
  endtask

  task automatic test_single();
    do_reset();
    inter_ready = 1'b1; req_valid = 3'b001;
    req_msg_type = {3'd0, 3'd0, 3'd2}; req_number = {5'd0, 5'd0, 5'd17}; #1;
    tests++; if (req_grant !== 3'b001 || transmit !== 0) begin
      fails++; $display("FAIL single_grant: grant %b tx %b want 001/0", req_grant, transmit); end
    cyc(); req_valid = '0; #1;
    tests++; if (transmit !== 1 || ctrl_en !== 1 || ctrl_msg_type !== 3'd2 || ctrl_number !== 5'd17) begin
      fails++; $display("FAIL single_launch: tx %b en %b type %0d num %0d want 1/1/2/17", transmit, ctrl_en, ctrl_msg_type, ctrl_number); end
    cyc(); inter_ready = 1'b0; #1;
    tests++; if (transmit !== 0 || ctrl_number !== 5'd17 || busy !== 1) begin
      fails++; $display("FAIL single_wait: tx %b num %0d busy %b want 0/17/1", transmit, ctrl_number, busy); end
    cyc(); #1;
    tests++; if (fifo_count !== 1) begin fails++; $display("FAIL single_held: count %0d want 1", fifo_count); end
    cyc(); inter_ready = 1'b1; #1;
    tests++; if (transmit !== 0 || ctrl_number !== 5'd17) begin
      fails++; $display("FAIL single_done: tx %b num %0d want 0/17", transmit, ctrl_number); end
    cyc(); #1;
    tests++; if (fifo_count !== 0 || busy !== 1 || transmit !== 0) begin
      fails++; $display("FAIL single_gap: count %0d busy %b tx %b want 0/1/0", fifo_count, busy, transmit); end
    cyc(); #1;
    tests++; if (busy !== 0) begin fails++; $display("FAIL single_idle: busy %b want 0", busy); end
  endtask

  task automatic test_fairness();
    logic [NR-1:0] exp_g [4];
    exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b001; exp_g[3] = 3'b010;
    do_reset();
    req_valid = 3'b011;
    for (int k = 0; k < 4; k++) begin
      #1;
      tests++; if (req_grant !== exp_g[k]) begin fails++; $display("FAIL fair_alt%0d: got %b want %b", k, req_grant, exp_g[k]); end
      cyc();
    end
    #1;
    tests++; if (req_grant !== 0 || fifo_count !== 4) begin
      fails++; $display("FAIL fair_full: grant %b count %0d want 000/4", req_grant, fifo_count); end
    do_reset();
    req_valid = 3'b011; cyc(); cyc();
    req_valid = 3'b111; #1;
    tests++; if (req_grant !== 3'b100) begin fails++; $display("FAIL fair_late2: got %b want 100", req_grant); end
    cyc(); req_valid = '0;
  endtask

  task automatic test_fifo_full();
    do_reset();
    req_valid = 3'b001;
    for (int k = 0; k < 4; k++) begin
      req_msg_type = 9'(k + 1); req_number = 15'(10 + k); #1;
      tests++; if (req_grant !== 3'b001) begin fails++; $display("FAIL full_push%0d: got %b want 001", k, req_grant); end
      cyc();
    end
    #1;
    tests++; if (req_grant !== 0 || fifo_count !== 4 || transmit !== 0) begin
      fails++; $display("FAIL full_block: grant %b count %0d tx %b want 000/4/0", req_grant, fifo_count, transmit); end
    req_valid = '0; inter_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      tests++; if (transmit !== 1 || ctrl_msg_type !== 3'(k + 1) || ctrl_number !== 5'(10 + k)) begin
        fails++; $display("FAIL full_launch%0d: tx %b type %0d num %0d want 1/%0d/%0d", k, transmit, ctrl_msg_type, ctrl_number, k + 1, 10 + k); end
      cyc(); inter_ready = 1'b0; #1;
      tests++; if (transmit !== 0) begin fails++; $display("FAIL full_nolaunch%0d: tx %b want 0", k, transmit); end
      cyc(); inter_ready = 1'b1; #1;
      tests++; if (ctrl_number !== 5'(10 + k) || fifo_count !== 3'(4 - k)) begin
        fails++; $display("FAIL full_hold%0d: num %0d count %0d want %0d/%0d", k, ctrl_number, fifo_count, 10 + k, 4 - k); end
      cyc(); #1;
      tests++; if (transmit !== 0 || fifo_count !== 3'(3 - k)) begin
        fails++; $display("FAIL full_gap%0d: tx %b count %0d want 0/%0d", k, transmit, fifo_count, 3 - k); end
      cyc();
    end
    #1;
    tests++; if (transmit !== 0 || busy !== 0 || fifo_count !== 0) begin
      fails++; $display("FAIL full_drained: tx %b busy %b count %0d want 0/0/0", transmit, busy, fifo_count); end
  endtask

  task automatic test_reset_mid();
    int bad;
    do_reset();
    req_valid = 3'b001; req_number = 15'd5; cyc(); cyc();
    req_valid = '0; inter_ready = 1'b1; #1;
    tests++; if (transmit !== 1 || fifo_count !== 2) begin
      fails++; $display("FAIL mid_launch: tx %b count %0d want 1/2", transmit, fifo_count); end
    cyc(); inter_ready = 1'b0; cyc(); #1;
    tests++; if (fifo_count !== 2 || busy !== 1) begin
      fails++; $display("FAIL mid_waitdone: count %0d busy %b want 2/1", fifo_count, busy); end
    rst = 1'b0; #1;
    tests++; if (fifo_count !== 0 || busy !== 0 || transmit !== 0) begin
      fails++; $display("FAIL mid_async: count %0d busy %b tx %b want 0/0/0", fifo_count, busy, transmit); end
    inter_ready = 1'b1; cyc(); cyc(); rst = 1'b1;
    bad = 0;
    for (int n = 0; n < 10; n++) begin
      #1; if (transmit !== 0) bad++;
      cyc();
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL mid_quiet: %0d transmit cycles want 0", bad); end
  endtask

`ifdef INTERBOARD_TX_RETRY_EN
  task automatic test_retry();
    logic exp_tx, exp_err;
    do_reset();
    inter_ready = 1'b1; req_valid = 3'b001; req_number = 15'd3; cyc();
    req_number = 15'd4; #1;
    tests++; if (transmit !== 1 || ctrl_number !== 5'd3) begin
      fails++; $display("FAIL retry_l0: tx %b num %0d want 1/3", transmit, ctrl_number); end
    cyc(); req_valid = '0;
    for (int n = 1; n <= 38; n++) begin
      #1;
      exp_tx  = (n == 9 || n == 18 || n == 27 || n == 38);
      exp_err = (n == 36);
      tests++; if (transmit !== exp_tx || tx_err !== exp_err) begin
        fails++; $display("FAIL retry_n%0d: tx %b err %b want %b/%b", n, transmit, tx_err, exp_tx, exp_err); end
      cyc();
    end
    #1;
    tests++; if (ctrl_number !== 5'd4 || fifo_count !== 1) begin
      fails++; $display("FAIL retry_next: num %0d count %0d want 4/1", ctrl_number, fifo_count); end
  endtask
`else
  task automatic test_stuck();
    int bad;
    do_reset();
    inter_ready = 1'b1; req_valid = 3'b001; req_number = 15'd9; cyc();
    req_valid = '0; #1;
    tests++; if (transmit !== 1) begin fails++; $display("FAIL stuck_launch: tx %b want 1", transmit); end
    bad = 0;
    for (int n = 0; n < 40; n++) begin
      cyc(); #1; if (transmit !== 0 || tx_err !== 0) bad++;
    end
    tests++; if (bad != 0 || fifo_count !== 1 || busy !== 1) begin
      fails++; $display("FAIL stuck_wait: bad %0d count %0d busy %b want 0/1/1", bad, fifo_count, busy); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_fifo_full();
    test_reset_mid();
`ifdef INTERBOARD_TX_RETRY_EN
    test_retry();
`else
    test_stuck();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
